// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per clock, WIDTH steps per operation.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Datapath registers: loaded on accept, so they carry no reset.
  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_a_orig;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_b;

  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mq_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_accept = start && (r_state != S_RUN);
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & operand_a[WIDTH-1];
  assign w_b_neg  = w_signed & operand_b[WIDTH-1];

  always_comb begin
    w_add     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
    w_shift   = {r_acc, r_mq[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_b};
    w_acc_nxt = w_add[WIDTH:1];
    w_mq_nxt  = {w_add[0], r_mq[WIDTH-1:1]};
    if (r_is_div) begin
      // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag.
      if (!w_diff[WIDTH]) begin
        w_acc_nxt = w_diff[WIDTH-1:0];
        w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shift[WIDTH-1:0];
        w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b0};
      end
    end
    w_prod   = f_neg_2w({w_acc_nxt, w_mq_nxt}, r_neg_lo);
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_res_hi = r_a_orig;
        w_res_lo = '1;
      end else begin
        w_res_hi = f_neg_w(w_acc_nxt, r_neg_hi);
        w_res_lo = f_neg_w(w_mq_nxt, r_neg_lo);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= op[1];
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_neg_hi <= w_a_neg;
      r_b_zero <= (operand_b == '0);
      r_a_orig <= operand_a;
      r_acc    <= '0;
      r_mq     <= f_abs(operand_a, w_signed);
      r_b      <= f_abs(operand_b, w_signed);
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_mq  <= w_mq_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_dbz   <= r_is_div & r_b_zero;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_done <= 1'b0;
          r_dbz  <= 1'b0;
          if (hi_we) r_hi <= write_data;
          if (lo_we) r_lo <= write_data;
          if (start) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against a plain-arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(a), .operand_b(b),
    .hi_we(hi_we), .lo_we(lo_we), .write_data(wd),
    .busy(busy), .done(done), .div_by_zero(dbz),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int sx, sy;
    logic [31:0] q, r;
    sx = x;
    sy = y;
    case (o)
      2'd0: begin
        p = longint'(sx) * longint'(sy);
        return {1'b0, p};
      end
      2'd1: begin
        p = {32'b0, x} * {32'b0, y};
        return {1'b0, p};
      end
      2'd2: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r, q};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = x / y;
        r = x % y;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // Called at #1 after a posedge (or earlier with inputs idle); accept happens on the next posedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit inject);
    logic [64:0] e;
    logic [31:0] h0, l0;
    int n;
    bit moved;
    e = model(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_accept", busy, 1'b1);
    check("done_low_on_accept", done, 1'b0);
    h0 = hi; l0 = lo; n = 0; moved = 0;
    while (!done && n < 40) begin
      if (inject && n == 10) begin
        start = 1'b1; op = ~o; a = 32'h1357_9BDF; b = 32'h3;
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h5A5A_5A5A;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (!done && (hi !== h0 || lo !== l0)) moved = 1;
    end
    check("latency", n, W);
    check("hold_while_busy", moved, 1'b0);
    check("hi", hi, e[63:32]);
    check("lo", lo, e[31:0]);
    check("div_by_zero", dbz, e[64]);
    check("busy_off_at_done", busy, 1'b0);
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("done_pulse_one_cycle", done, 1'b0);
    check("dbz_low_after_done", dbz, 1'b0);
    check("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    logic [31:0] corner [6];
    logic [31:0] x, y;
    logic [1:0]  o;
    bit seen;
    corner[0] = 32'h0;        corner[1] = 32'h1;        corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h2;

    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = '0; b = '0; wd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", dbz, 1'b0);
    rst = 1'b0;

    // MTLO / MTHI in IDLE
    lo_we = 1'b1; wd = 32'h0000_CAFE;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_CAFE);
    check("mtlo_hi_untouched", hi, 32'h0);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", hi, 32'h1234_5678);
    check("mt_both_lo", lo, 32'h1234_5678);

    // Reset in the middle of a MULTU
    op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("midrst_no_done", seen, 1'b0);

    // Directed cases
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 32'h0000_0001);
    idle_check();
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
    idle_check();
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    check("div_neg_hi_const", hi, 32'hFFFF_FFFF);
    idle_check();
    run_op(2'd3, 32'd100, 32'd7, 0);
    idle_check();
    run_op(2'd3, 32'h1234, 32'h0, 0);
    check("divu_zero_hi_const", hi, 32'h1234);
    idle_check();
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle_check();
    run_op(2'd2, 32'hFFFF_FF00, 32'h0, 0);
    idle_check();

    // Start and MTHI/MTLO pulsed while busy
    run_op(2'd0, 32'h8765_4321, 32'h0BAD_F00D, 1);
    idle_check();

    // Back-to-back: second start issued in the DONE cycle
    run_op(2'd3, 32'd1000, 32'd33, 0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);
    idle_check();

    // MTHI together with start: write lands at accept, result overwrites later
    hi_we = 1'b1; wd = 32'hDEAD_BEEF;
    op = 2'd1; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b0;
    check("mthi_with_start", hi, 32'hDEAD_BEEF);
    seen = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
    end
    check("mthi_with_start_result_hi", hi, 32'h0);
    check("mthi_with_start_result_lo", lo, 32'd30);
    idle_check();

    // Randomized operations
    for (int k = 0; k < 150; k++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 5))
        0: y = corner[$urandom_range(0, 5)];
        1: y = 32'($urandom_range(0, 20));
        default: y = $urandom;
      endcase
      run_op(o, x, y, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 2) != 0) idle_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
